// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing defaults, pin-bus bit positions and small helpers
// for the VGA sync generator and capture monitor.
package vga_timing_pkg;

    localparam int H_ACTIVE_DFLT = 640;
    localparam int H_FP_DFLT     = 16;
    localparam int H_SYNC_DFLT   = 96;
    localparam int H_BP_DFLT     = 48;
    localparam int V_ACTIVE_DFLT = 480;
    localparam int V_FP_DFLT     = 10;
    localparam int V_SYNC_DFLT   = 2;
    localparam int V_BP_DFLT     = 33;

    localparam int PIN_R1    = 0;
    localparam int PIN_G1    = 1;
    localparam int PIN_B1    = 2;
    localparam int PIN_VSYNC = 3;
    localparam int PIN_R0    = 4;
    localparam int PIN_G0    = 5;
    localparam int PIN_B0    = 6;
    localparam int PIN_HSYNC = 7;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_HTRACK = 2'd1,
        ST_VTRACK = 2'd2,
        ST_LOCKED = 2'd3
    } track_state_e;

    function automatic logic [5:0] decode_rgb(input logic [7:0] pins);
        return {pins[PIN_R1], pins[PIN_R0], pins[PIN_G1],
                pins[PIN_G0], pins[PIN_B1], pins[PIN_B0]};
    endfunction

    function automatic logic [15:0] sig_step(input logic [15:0] sum, input logic [5:0] px);
        return {sum[14:0], sum[15]} ^ {10'd0, px};
    endfunction

endpackage

// File: rtl/vga_frame_signature.sv
// Per-frame rotate-xor signature and lit-pixel count over the locked visible
// area, latched with a one-cycle frame_done after the last visible pixel.
module vga_frame_signature
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DFLT,
    parameter int V_ACTIVE = V_ACTIVE_DFLT
) (
    input  logic        px_clk,
    input  logic        reset,
    input  logic        locked,
    input  logic        activevideo,
    input  logic [9:0]  x_px,
    input  logic [9:0]  y_px,
    input  logic [5:0]  rrggbb,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [18:0] frame_lit
);

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    logic [15:0] sum_r;
    logic [18:0] lit_r;
    logic [15:0] sum_nxt_s;
    logic [18:0] lit_nxt_s;
    logic        last_px_s;

    // Next accumulator values and end-of-frame detection for the reported pixel
    always_comb begin
        sum_nxt_s = sig_step(sum_r, rrggbb);
        lit_nxt_s = lit_r + 19'(rrggbb != 6'd0);
        last_px_s = activevideo && (x_px == X_LAST) && (y_px == Y_LAST);
    end

    // Accumulate while locked, publish and restart on the last visible pixel
    always_ff @(posedge px_clk) begin
        if (reset) begin
            sum_r      <= 16'd0;
            lit_r      <= 19'd0;
            frame_done <= 1'b0;
            frame_sum  <= 16'd0;
            frame_lit  <= 19'd0;
        end else if (!locked) begin
            sum_r      <= 16'd0;
            lit_r      <= 19'd0;
            frame_done <= 1'b0;
        end else if (last_px_s) begin
            frame_sum  <= sum_nxt_s;
            frame_lit  <= lit_nxt_s;
            frame_done <= 1'b1;
            sum_r      <= 16'd0;
            lit_r      <= 19'd0;
        end else if (activevideo) begin
            sum_r      <= sum_nxt_s;
            lit_r      <= lit_nxt_s;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
        end
    end

endmodule

// File: rtl/vga_capture_monitor.sv
// Samples the VGA pin bus, recovers pixel coordinates from sync edges,
// checks sync placement and reports a per-frame signature.
module vga_capture_monitor
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE        = H_ACTIVE_DFLT,
    parameter int H_FP            = H_FP_DFLT,
    parameter int H_SYNC          = H_SYNC_DFLT,
    parameter int H_BP            = H_BP_DFLT,
    parameter int V_ACTIVE        = V_ACTIVE_DFLT,
    parameter int V_FP            = V_FP_DFLT,
    parameter int V_SYNC          = V_SYNC_DFLT,
    parameter int V_BP            = V_BP_DFLT,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        px_clk,
    input  logic        reset,
    input  logic [7:0]  vga_in,
    output logic [9:0]  x_px,
    output logic [9:0]  y_px,
    output logic [5:0]  rrggbb,
    output logic        activevideo,
    output logic        locked,
    output logic        sync_err,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [18:0] frame_lit
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_RISE   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_FALL   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_RISE   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_FALL   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic       SYNC_INV = (SYNC_ACTIVE_LOW != 0);

    logic [7:0]   pins_r;
    logic [7:0]   pins_prev_r;
    logic [9:0]   h_r;
    logic [9:0]   v_r;
    track_state_e state_r;
    track_state_e state_nxt_s;

    logic       hs_s, vs_s, hs_prev_s, vs_prev_s;
    logic       hs_rise_s, hs_fall_s, vs_rise_s, vs_fall_s;
    logic       h_load_s, v_load_s, h_wrap_s;
    logic [9:0] h_cur_s, v_cur_s, v_inc_s;
    logic       edge_err_s;

    assign hs_s      = pins_r[PIN_HSYNC] ^ SYNC_INV;
    assign vs_s      = pins_r[PIN_VSYNC] ^ SYNC_INV;
    assign hs_prev_s = pins_prev_r[PIN_HSYNC] ^ SYNC_INV;
    assign vs_prev_s = pins_prev_r[PIN_VSYNC] ^ SYNC_INV;
    assign hs_rise_s = hs_s & ~hs_prev_s;
    assign hs_fall_s = ~hs_s & hs_prev_s;
    assign vs_rise_s = vs_s & ~vs_prev_s;
    assign vs_fall_s = ~vs_s & vs_prev_s;

    // Coordinates of the stage-1 sample: loads win over increments, v follows h wraps
    always_comb begin
        h_load_s = (state_r == ST_SEARCH) && hs_rise_s;
        v_load_s = (state_r == ST_HTRACK) && vs_rise_s;
        h_wrap_s = !h_load_s && (h_r == H_LAST);
        if (h_load_s) begin
            h_cur_s = H_RISE;
        end else if (h_wrap_s) begin
            h_cur_s = 10'd0;
        end else begin
            h_cur_s = h_r + 10'd1;
        end
        if (v_r == V_LAST) begin
            v_inc_s = 10'd0;
        end else begin
            v_inc_s = v_r + 10'd1;
        end
        if (v_load_s) begin
            v_cur_s = V_RISE;
        end else if (h_wrap_s) begin
            v_cur_s = v_inc_s;
        end else begin
            v_cur_s = v_r;
        end
    end

    // Misplaced-edge detection and tracker state transitions
    always_comb begin
        if (state_r != ST_SEARCH) begin
            edge_err_s = (hs_rise_s && (h_cur_s != H_RISE)) ||
                         (hs_fall_s && (h_cur_s != H_FALL)) ||
                         (vs_rise_s && (v_cur_s != V_RISE)) ||
                         (vs_fall_s && (v_cur_s != V_FALL));
        end else begin
            edge_err_s = 1'b0;
        end
        state_nxt_s = state_r;
        if (edge_err_s) begin
            state_nxt_s = ST_SEARCH;
        end else begin
            case (state_r)
                ST_SEARCH: state_nxt_s = hs_rise_s ? ST_HTRACK : ST_SEARCH;
                ST_HTRACK: state_nxt_s = vs_rise_s ? ST_VTRACK : ST_HTRACK;
                ST_VTRACK: state_nxt_s = vs_rise_s ? ST_LOCKED : ST_VTRACK;
                ST_LOCKED: state_nxt_s = ST_LOCKED;
                default:   state_nxt_s = ST_SEARCH;
            endcase
        end
    end

    // Two-stage capture pipeline, counters, tracker state and registered outputs
    always_ff @(posedge px_clk) begin
        if (reset) begin
            pins_r      <= 8'd0;
            pins_prev_r <= 8'd0;
            h_r         <= 10'd0;
            v_r         <= 10'd0;
            state_r     <= ST_SEARCH;
            x_px        <= 10'd0;
            y_px        <= 10'd0;
            rrggbb      <= 6'd0;
            activevideo <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            pins_r      <= vga_in;
            pins_prev_r <= pins_r;
            h_r         <= h_cur_s;
            v_r         <= v_cur_s;
            state_r     <= state_nxt_s;
            x_px        <= h_cur_s;
            y_px        <= v_cur_s;
            rrggbb      <= decode_rgb(pins_r);
            activevideo <= (state_nxt_s == ST_LOCKED) && (h_cur_s < H_VIS) && (v_cur_s < V_VIS);
            locked      <= (state_nxt_s == ST_LOCKED);
            sync_err    <= edge_err_s;
        end
    end

    vga_frame_signature #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_signature (
        .px_clk      (px_clk),
        .reset       (reset),
        .locked      (locked),
        .activevideo (activevideo),
        .x_px        (x_px),
        .y_px        (y_px),
        .rrggbb      (rrggbb),
        .frame_done  (frame_done),
        .frame_sum   (frame_sum),
        .frame_lit   (frame_lit)
    );

endmodule
